// File: rtl/dut_memory_pkg.sv
// Shared types and defaults for the fixed-latency memory model
// that sits downstream of the processor.
package dut_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic logic lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/dut_memory_read_delay_line.sv
// Fixed-depth register chain that delays read data to the programmed
// latency; every stage clears asynchronously so in-flight reads die on reset.
module read_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/dut_memory.sv
// Word-addressed memory with post-reset clearing sweep, sticky out-of-range
// flag, saturating access counters and a fixed registered read latency.
module dut_memory
  import dut_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataToMemory,
  input  logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] dataFromMemory,
  output logic                  initDone,
  output logic                  outOfRange,
  output logic [CNT_WIDTH-1:0]  readCount,
  output logic [CNT_WIDTH-1:0]  writeCount
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  if (!lat_legal(READ_LATENCY)) begin : g_bad_latency
    $error("dut_memory: READ_LATENCY must lie in 1..4");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > ADDR_WIDTH) begin : g_bad_depth
    $error("dut_memory: DEPTH_LOG2 must lie in 1..ADDR_WIDTH");
  end

  mem_state_t            r_state, w_next_state;
  logic [DEPTH_LOG2-1:0] r_clear_ptr;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_feed, w_mem_wdata;
  logic [DEPTH_LOG2-1:0] w_addr_lo, w_mem_waddr;
  logic [CNT_WIDTH-1:0]  r_read_cnt, r_write_cnt;
  logic                  r_oor;
  logic                  w_in_range, w_mem_we, w_dut_wr, w_dut_rd;

  assign w_addr_lo  = address[DEPTH_LOG2-1:0];
  assign w_in_range = (address >> DEPTH_LOG2) == '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == CLEAR && r_clear_ptr == '1) w_next_state = READY;
  end

  // The sweep owns the write port in CLEAR; the processor owns it in READY.
  always_comb begin
    initDone    = (r_state == READY);
    w_dut_wr    = 1'b0;
    w_dut_rd    = 1'b0;
    w_mem_we    = 1'b1;
    w_mem_waddr = r_clear_ptr;
    w_mem_wdata = '0;
    if (r_state == READY) begin
      w_dut_wr    = writeEnable && w_in_range;
      w_dut_rd    = !writeEnable && w_in_range;
      w_mem_we    = w_dut_wr;
      w_mem_waddr = w_addr_lo;
      w_mem_wdata = dataToMemory;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_clear_ptr <= '0;
    else if (r_state == CLEAR) r_clear_ptr <= r_clear_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Write-first: a write returns its own data through the read path.
  always_comb begin
    w_rd_feed = '0;
    if (w_dut_wr)      w_rd_feed = dataToMemory;
    else if (w_dut_rd) w_rd_feed = r_mem[w_addr_lo];
  end

  // Synchronous read register: the sampling edge; the delay line adds the latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= w_rd_feed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_oor       <= 1'b0;
    end else begin
      if (w_dut_rd && r_read_cnt != '1)  r_read_cnt  <= r_read_cnt + 1'b1;
      if (w_dut_wr && r_write_cnt != '1) r_write_cnt <= r_write_cnt + 1'b1;
      if (r_state == READY && !w_in_range) r_oor <= 1'b1;
    end
  end

  assign readCount  = r_read_cnt;
  assign writeCount = r_write_cnt;
  assign outOfRange = r_oor;

  read_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_rd_dly (
    .clk   (clk),
    .reset (reset),
    .i_d   (r_rd_data),
    .o_q   (dataFromMemory)
  );

endmodule

// File: tb/tb_dut_memory.sv
// Bench for dut_memory: directed vector table, reference-model random traffic,
// sweep length, out-of-range, mid-burst reset and counter saturation.
module tb_dut_memory;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DL = 4;
  localparam int RL = 2;
  localparam int CW = 4;
  localparam int WORDS = 1 << DL;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] dataToMemory;
  logic          writeEnable;
  logic [DW-1:0] dataFromMemory;
  logic          initDone;
  logic          outOfRange;
  logic [CW-1:0] readCount;
  logic [CW-1:0] writeCount;

  dut_memory #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH_LOG2   (DL),
    .READ_LATENCY (RL),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .dataToMemory   (dataToMemory),
    .writeEnable    (writeEnable),
    .dataFromMemory (dataFromMemory),
    .initDone       (initDone),
    .outOfRange     (outOfRange),
    .readCount      (readCount),
    .writeCount     (writeCount)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: memory words, remaining sweep cycles, counts, and a
  // latency queue whose head is the value due on dataFromMemory.
  logic [DW-1:0] m_mem [WORDS];
  int            m_sweep_left;
  int            m_rc, m_wc;
  logic          m_oor;
  logic [DW-1:0] m_pipe [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sweep_left = WORDS;
    m_rc = 0;
    m_wc = 0;
    m_oor = 1'b0;
    m_pipe.delete();
    for (int i = 0; i <= RL; i++) m_pipe.push_back('0);
  endtask

  task automatic model_edge(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] feed;
    feed = '0;
    if (m_sweep_left > 0) begin
      m_mem[WORDS - m_sweep_left] = '0;
      m_sweep_left--;
    end else if (int'(a) < WORDS) begin
      if (we) begin
        m_mem[a[DL-1:0]] = d;
        feed = d;
        m_wc = (m_wc >= CNT_MAX) ? CNT_MAX : m_wc + 1;
      end else begin
        feed = m_mem[a[DL-1:0]];
        m_rc = (m_rc >= CNT_MAX) ? CNT_MAX : m_rc + 1;
      end
    end else begin
      m_oor = 1'b1;
    end
    m_pipe.push_back(feed);
    void'(m_pipe.pop_front());
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".dout"}, 32'(dataFromMemory), 32'(m_pipe[0]));
    chk({tag, ".initDone"}, 32'(initDone), 32'(m_sweep_left == 0));
    chk({tag, ".oor"}, 32'(outOfRange), 32'(m_oor));
    chk({tag, ".rc"}, 32'(readCount), 32'(m_rc));
    chk({tag, ".wc"}, 32'(writeCount), 32'(m_wc));
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    writeEnable  = we;
    address      = a;
    dataToMemory = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1;
    model_check(tag);
  endtask

  // Runs the sweep, poking a write during CLEAR, and returns the edge count to initDone.
  task automatic run_sweep(output int edges);
    edges = 0;
    while (!initDone && edges < 4 * WORDS) begin
      if (edges == 3) cycle(1'b1, 16'h0002, 16'h1234, "sweep");
      else            cycle(1'b0, 16'h0000, 16'h0000, "sweep");
      edges++;
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_dout;
    logic [CW-1:0] exp_wc;
    logic [CW-1:0] exp_rc;
    logic          exp_oor;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    vecs[0]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000, 4'd1, 4'd0,  1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 16'h1111, 16'h0000, 4'd2, 4'd0,  1'b0};
    vecs[2]  = '{1'b0, 16'h0003, 16'hDEAD, 16'hBEEF, 4'd2, 4'd1,  1'b0};
    vecs[3]  = '{1'b0, 16'h0002, 16'hDEAD, 16'h1111, 4'd2, 4'd2,  1'b0};
    vecs[4]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 4'd2, 4'd3,  1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd2, 4'd4,  1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h1111, 4'd2, 4'd5,  1'b0};
    vecs[7]  = '{1'b1, 16'h0010, 16'h5555, 16'h0000, 4'd2, 4'd5,  1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd2, 4'd6,  1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd2, 4'd7,  1'b1};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd2, 4'd8,  1'b1};
    vecs[11] = '{1'b1, 16'h0007, 16'hA5A5, 16'h0000, 4'd3, 4'd8,  1'b1};
    vecs[12] = '{1'b0, 16'h0007, 16'h0000, 16'h0000, 4'd3, 4'd9,  1'b1};
    vecs[13] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 4'd3, 4'd9,  1'b1};
    vecs[14] = '{1'b0, 16'h0003, 16'h0000, 16'hA5A5, 4'd3, 4'd10, 1'b1};
    vecs[15] = '{1'b0, 16'h0003, 16'h0000, 16'h0000, 4'd3, 4'd11, 1'b1};

    reset = 1'b1;
    writeEnable = 1'b0;
    address = '0;
    dataToMemory = '0;
    model_reset();
    #12;
    chk("rst.dout", 32'(dataFromMemory), 32'h0);
    chk("rst.initDone", 32'(initDone), 32'h0);
    chk("rst.oor", 32'(outOfRange), 32'h0);
    chk("rst.rc", 32'(readCount), 32'h0);
    chk("rst.wc", 32'(writeCount), 32'h0);
    reset = 1'b0;

    run_sweep(edges);
    chk("sweep1.len", 32'(edges), 32'(WORDS));

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].data, "vec");
      chk($sformatf("vec%0d.dout", i), 32'(dataFromMemory), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d.wc", i), 32'(writeCount), 32'(vecs[i].exp_wc));
      chk($sformatf("vec%0d.rc", i), 32'(readCount), 32'(vecs[i].exp_rc));
      chk($sformatf("vec%0d.oor", i), 32'(outOfRange), 32'(vecs[i].exp_oor));
    end

    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 19));
      cycle(1'($urandom), a, DW'($urandom), "rand");
    end

    for (int i = 0; i < WORDS; i++) cycle(1'b1, AW'(i), 16'hC000 | DW'(i), "fill");
    for (int i = 0; i < 6; i++) cycle(1'b0, AW'(i), 16'h0000, "burst");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst.dout", 32'(dataFromMemory), 32'h0);
    chk("midrst.initDone", 32'(initDone), 32'h0);
    chk("midrst.oor", 32'(outOfRange), 32'h0);
    chk("midrst.rc", 32'(readCount), 32'h0);
    chk("midrst.wc", 32'(writeCount), 32'h0);
    #2;
    reset = 1'b0;

    run_sweep(edges);
    chk("sweep2.len", 32'(edges), 32'(WORDS));

    for (int i = 0; i < 20; i++) cycle(1'b0, AW'(i % WORDS), 16'h0000, "sat");
    chk("sat.rc", 32'(readCount), 32'hF);
    chk("sat.wc", 32'(writeCount), 32'h0);
    cycle(1'b0, 16'h0000, 16'h0000, "tail");
    cycle(1'b0, 16'h0000, 16'h0000, "tail");
    chk("sat.dout_zero", 32'(dataFromMemory), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
